// File: rtl/timer_alarm_scheduler_pkg.sv
// Shared constants for the timer alarm scheduler: timer register map,
// control register bits and the scheduler FSM encoding.
package timer_alarm_scheduler_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_PL    = 4'd1,
        S_WR_PH    = 4'd2,
        S_WR_CLR0  = 4'd3,
        S_WR_CTL   = 4'd4,
        S_WAIT_IRQ = 4'd5,
        S_WR_CLR1  = 4'd6,
        S_WR_STOP  = 4'd7,
        S_DONE     = 4'd8
    } state_e;

endpackage

// File: rtl/timer_alarm_scheduler_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Produces a one-hot grant and the matching index; purely combinational.
module timer_alarm_scheduler_rr_arbiter
    import timer_alarm_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               any_o,
    output logic [IDW-1:0]     idx_o,
    output logic [NUM_REQ-1:0] gnt_o
);

    // Requests padded to the full index range so any IDW-bit index is legal.
    localparam int EXT = 1 << IDW;

    logic [EXT-1:0] req_ext;
    logic [IDW:0]   cand;   // one extra bit holds ptr+i before wrapping

    // Scan from the pointer upwards and keep the first requester found.
    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req_i;
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!any_o && req_ext[cand[IDW-1:0]]) begin
                any_o = 1'b1;
                idx_o = cand[IDW-1:0];
            end
        end
    end

    // One-hot view of the chosen index.
    always_comb begin
        gnt_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (any_o && idx_o == IDW'(j)) begin
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Shares one 32-bit interval timer between NUM_REQ requesters. A granted job
// programs period, clears status, starts the timer one-shot, waits for irq,
// then clears/stops the timer and pulses done to the requester.
// Bus handshake: every timer access is a single-cycle write (chipselect=1,
// write_n=0); the timer never stalls and is never read.
module timer_alarm_scheduler
    import timer_alarm_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   delay,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output logic [IDW-1:0]          active_id,
    output logic [2:0]              timer_address,
    output logic                    timer_chipselect,
    output logic                    timer_write_n,
    output logic [15:0]             timer_writedata,
    input  logic                    timer_irq,
    output state_e                  dbg_state
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, id_q;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q;
    logic [15:0]          delay_hi_q;
    logic                 busy_q;
    logic [2:0]           addr_q, addr_d;
    logic                 cs_q, cs_d, wn_q, wn_d;
    logic [15:0]          wdata_q, wdata_d;

    logic                 arb_any;
    logic [IDW-1:0]       arb_idx;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [31:0]          sel_delay;
    logic                 grant;

    timer_alarm_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .any_o (arb_any),
        .idx_o (arb_idx),
        .gnt_o (arb_gnt)
    );

    // Delay slice of the requester the arbiter is currently pointing at.
    always_comb begin
        sel_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_delay = delay[32*i +: 32];
            end
        end
    end

    assign grant = (state_q == S_IDLE) && arb_any;
    assign gnt_d = grant ? arb_gnt : gnt_q;

    // Next-state logic: one cycle per state except IDLE and WAIT_IRQ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (arb_any) state_d = (sel_delay == '0) ? S_DONE : S_WR_PL;
            S_WR_PL:    state_d = S_WR_PH;
            S_WR_PH:    state_d = S_WR_CLR0;
            S_WR_CLR0:  state_d = S_WR_CTL;
            S_WR_CTL:   state_d = S_WAIT_IRQ;
            S_WAIT_IRQ: if (timer_irq) state_d = S_WR_CLR1;
            S_WR_CLR1:  state_d = S_WR_STOP;
            S_WR_STOP:  state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus values for the state being entered, so the registered bus lines
    // carry each write during its own state. WR_PL is only entered from
    // IDLE, where the arbiter's delay is still the live source.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = ADDR_STATUS;
        wdata_d = '0;
        case (state_d)
            S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wdata_d = sel_delay[15:0]; end
            S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wdata_d = delay_hi_q; end
            S_WR_CLR0: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;   wdata_d = '0; end
            S_WR_CTL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTRL_START | CTRL_ITO; end
            S_WR_CLR1: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;   wdata_d = '0; end
            S_WR_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTRL_STOP; end
            default:   ;
        endcase
    end

    // State, job latch, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            delay_hi_q <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            wn_q       <= 1'b1;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (grant) begin
                id_q       <= arb_idx;
                delay_hi_q <= sel_delay[31:16];
            end
            if (state_q == S_DONE) begin
                ptr_q <= (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + IDW'(1);
            end
            done_q  <= (state_d == S_DONE) ? gnt_d : '0;
            busy_q  <= (state_d != S_IDLE);
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
        end
    end

    assign done             = done_q;
    assign busy             = busy_q;
    assign active_id        = id_q;
    assign timer_address    = addr_q;
    assign timer_chipselect = cs_q;
    assign timer_write_n    = wn_q;
    assign timer_writedata  = wdata_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed bench for timer_alarm_scheduler: a stub irq or a behavioural
// interval timer drives timer_irq; expected bus writes and done pulses are
// queued at stimulus time and checked as the DUT produces them.
module tb_timer_alarm_scheduler;
    import timer_alarm_scheduler_pkg::*;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] delay;
    logic [3:0]   done;
    logic         busy;
    logic [2:0]   active_id;
    logic [2:0]   timer_address;
    logic         timer_chipselect;
    logic         timer_write_n;
    logic [15:0]  timer_writedata;
    logic         timer_irq;
    state_e       dbg_state;

    logic         use_model;
    logic         stub_irq;

    int total = 0;
    int bad   = 0;

    logic [18:0] exp_q[$];       // {address, writedata}
    logic [3:0]  exp_done_q[$];

    timer_alarm_scheduler #(.NUM_REQ(4), .IDW(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .delay            (delay),
        .done             (done),
        .busy             (busy),
        .active_id        (active_id),
        .timer_address    (timer_address),
        .timer_chipselect (timer_chipselect),
        .timer_write_n    (timer_write_n),
        .timer_writedata  (timer_writedata),
        .timer_irq        (timer_irq),
        .dbg_state        (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Behavioural interval timer: period write reloads and stops, START runs,
    // counts down to zero then raises TO; one-shot unless CONT.
    logic [15:0] m_pl = '0, m_ph = '0;
    logic [31:0] m_cnt = '0;
    logic        m_run = 1'b0, m_to = 1'b0, m_ito = 1'b0, m_cont = 1'b0;

    always @(posedge clk) begin
        if (timer_chipselect && !timer_write_n) begin
            case (timer_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito  <= timer_writedata[0];
                    m_cont <= timer_writedata[1];
                    if (timer_writedata[3]) m_run <= 1'b0;
                    else if (timer_writedata[2]) m_run <= 1'b1;
                end
                3'd2: begin m_pl <= timer_writedata; m_cnt <= {m_ph, timer_writedata}; m_run <= 1'b0; end
                3'd3: begin m_ph <= timer_writedata; m_cnt <= {timer_writedata, m_pl}; m_run <= 1'b0; end
                default: ;
            endcase
        end else if (m_run) begin
            if (m_cnt == 0) begin
                m_to  <= 1'b1;
                m_cnt <= {m_ph, m_pl};
                if (!m_cont) m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign timer_irq = use_model ? (m_to & m_ito) : stub_irq;

    // Comparison helper
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver helpers
    task automatic push_writes(input logic [31:0] d);
        exp_q.push_back({3'd2, d[15:0]});
        exp_q.push_back({3'd3, d[31:16]});
        exp_q.push_back({3'd0, 16'h0000});
        exp_q.push_back({3'd1, 16'h0005});
        exp_q.push_back({3'd0, 16'h0000});
        exp_q.push_back({3'd1, 16'h0008});
    endtask

    // Runs one job against the behavioural timer, starting from idle.
    task automatic run_model_job(input int id, input logic [31:0] d, input bit drop_in_ctl);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        push_writes(d);
        exp_done_q.push_back(oh);
        delay[32*id +: 32] = d;
        req = req | oh;
        repeat (4) @(negedge clk);
        chk("job_start_write", {timer_chipselect, timer_write_n, timer_address, timer_writedata},
            {1'b1, 1'b0, 3'd1, 16'h0005});
        if (drop_in_ctl) req = req & ~oh;
        n = 0;
        while (timer_irq !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("job_irq_seen", timer_irq, 1);
        chk("job_irq_not_early", (n >= int'(d) + 1), 1);
        repeat (3) @(negedge clk);
        chk("job_done_pulse", done, oh);
        req = req & ~oh;
        @(negedge clk);
        chk("job_done_once", {busy, done}, 5'b0);
    endtask

    // Scoreboard: every bus write and done pulse pops its expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (timer_chipselect) begin
                if (exp_q.size() == 0) chk("unexpected_write_cs", timer_chipselect, 0);
                else chk("bus_write", {timer_write_n, timer_address, timer_writedata}, {1'b0, exp_q.pop_front()});
            end
            if (done != 4'b0) begin
                if (exp_done_q.size() == 0) chk("unexpected_done", done, 0);
                else chk("done_order", done, exp_done_q.pop_front());
            end
        end
    end

    // Directed sequence
    initial begin
        int n_done;
        int cyc;
        reset     = 1'b1;
        req       = '0;
        delay     = '0;
        stub_irq  = 1'b0;
        use_model = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done_busy_id", {done, busy, active_id}, 8'h00);
        chk("rst_bus_ctl", {timer_chipselect, timer_write_n}, 2'b01);
        chk("rst_bus_addr_data", {timer_address, timer_writedata}, 19'h0);
        chk("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Single job with stub irq
        delay[32*1 +: 32] = 32'h0001_86A0;
        push_writes(32'h0001_86A0);
        exp_done_q.push_back(4'b0010);
        req = 4'b0010;
        @(negedge clk);
        chk("single_busy_id", {busy, active_id}, {1'b1, 3'd1});
        repeat (3) @(negedge clk);
        chk("single_start_latency", {timer_chipselect, timer_address}, {1'b1, 3'd1});
        @(negedge clk);
        chk("single_wait_bus_idle", timer_chipselect, 0);
        repeat (100) @(negedge clk);
        chk("single_still_waiting", {busy, done}, {1'b1, 4'b0});
        stub_irq = 1'b1;
        @(negedge clk);
        stub_irq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("single_done_3_after_irq", done, 4'b0010);
        req = 4'b0;
        @(negedge clk);
        chk("single_idle_after", {busy, done}, 5'b0);

        // Zero delay: done one cycle after grant, no bus traffic
        delay = '0;
        exp_done_q.push_back(4'b0100);
        req = 4'b0100;
        @(negedge clk);
        chk("zero_done", {done, timer_chipselect}, {4'b0100, 1'b0});
        req = 4'b0;
        @(negedge clk);
        chk("zero_idle", {busy, timer_chipselect}, 2'b0);

        // Spurious irq in IDLE and through WR_PL
        stub_irq = 1'b1;
        repeat (5) @(negedge clk);
        chk("spur_idle_ignored", {busy, timer_chipselect}, 2'b0);
        delay[32*3 +: 32] = 32'd7;
        push_writes(32'd7);
        exp_done_q.push_back(4'b1000);
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        stub_irq = 1'b0;
        repeat (23) @(negedge clk);
        chk("spur_still_waiting", {busy, done, dbg_state}, {1'b1, 4'b0, S_WAIT_IRQ});
        stub_irq = 1'b1;
        @(negedge clk);
        stub_irq = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_done", done, 4'b1000);
        req = 4'b0;
        @(negedge clk);
        chk("spur_idle_after", busy, 0);

        // Round-robin with all requesters pending and a real timer
        use_model = 1'b1;
        for (int i = 0; i < 4; i++) delay[32*i +: 32] = 32'd5;
        for (int k = 0; k < 5; k++) begin
            push_writes(32'd5);
            exp_done_q.push_back(4'b0001 << (k % 4));
        end
        req = 4'b1111;
        n_done = 0;
        cyc = 0;
        while (n_done < 5 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done != 4'b0) begin
                n_done++;
                if (n_done == 5) req = 4'b0;
            end
        end
        chk("rr_done_count", n_done, 5);
        @(negedge clk);
        chk("rr_idle", busy, 0);

        // Request dropped during WR_CTL still completes
        run_model_job(3, 32'd4, 1'b1);

        // Reset while waiting for irq
        delay[31:0] = 32'd40;
        exp_q.push_back({3'd2, 16'd40});
        exp_q.push_back({3'd3, 16'd0});
        exp_q.push_back({3'd0, 16'h0000});
        exp_q.push_back({3'd1, 16'h0005});
        req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("rstjob_in_wait", dbg_state, S_WAIT_IRQ);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        req = 4'b0;
        @(negedge clk);
        chk("rstjob_done_busy_id", {done, busy, active_id}, 8'h00);
        chk("rstjob_bus", {timer_chipselect, timer_write_n, timer_address, timer_writedata},
            {1'b0, 1'b1, 3'd0, 16'h0});
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("rstjob_stale_irq_ignored", busy, 0);
        run_model_job(2, 32'd3, 1'b0);

        repeat (5) @(negedge clk);
        chk("writes_drained", exp_q.size(), 0);
        chk("dones_drained", exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
